screen_arbiter: RTL and testbench
=================================

SCREEN_ARBITER -- requirements
Module: screen_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, prefetch FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter SCREEN_WORDS, default 8192, words per frame.
REQ-003 SHALL have ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU accesses screen memory this cycle.
- cpu_write  in  1  CPU write strobe, qualified by cpu_req.
- cpu_address  in  13  CPU word address.
- cpu_data  in  16  CPU write data.
- cpu_rdata  out  16  screen read data to CPU.
- mem_address  out  13  screen RAM address.
- mem_data  out  16  screen RAM write data.
- mem_write  out  1  screen RAM write enable.
- mem_rdata  in  16  screen RAM read data, valid one cycle after address.
- vid_start  in  1  one-cycle frame-start pulse.
- vid_ready  in  1  scanout accepts a word.
- vid_word  out  16  FIFO head word.
- vid_valid  out  1  FIFO non-empty.
- underruns  out  16  saturating underrun count.

Function
REQ-004 SHALL grant the RAM port to the CPU in any cycle with cpu_req=1; CPU has absolute priority and never stalls.
- CPU cycle: mem_address=cpu_address, mem_data=cpu_data, mem_write=cpu_write.
REQ-005 SHALL drive cpu_rdata=mem_rdata combinationally; CPU read data is valid the cycle after cpu_req.
REQ-006 SHALL never assert mem_write in a non-CPU cycle.
REQ-007 SHALL implement FSM IDLE, RUN, DRAIN.
- IDLE -> RUN on vid_start.
- RUN -> DRAIN after fetch of word SCREEN_WORDS-1 is issued.
- DRAIN -> IDLE when no fetch is in flight and FIFO is empty.
REQ-008 In RUN, SHALL issue a fetch (mem_address=fetch_addr) in a cycle iff cpu_req=0 and fifo_count+inflight<FIFO_DEPTH; fetch_addr then increments.
REQ-009 SHALL push mem_rdata into the FIFO the cycle after each issued fetch (inflight is 0 or 1).
REQ-010 SHALL pop the FIFO head on vid_valid && vid_ready; push and pop in the same cycle SHALL leave count unchanged, including when full.
REQ-011 SHALL increment underruns (saturating at 16'hFFFF) each cycle in RUN or DRAIN with vid_ready=1 and FIFO empty; no increment in IDLE.
REQ-012 vid_start in RUN or DRAIN SHALL restart the frame:
- flush FIFO.
- discard in-flight data.
- fetch_addr=0.
- state RUN.
- underruns retained.
REQ-013 vid_start coincident with cpu_req SHALL restart the frame and give the CPU the port; the first fetch waits for a free cycle.
REQ-014 fetch_addr SHALL wrap to 0 only via vid_start; no fetch beyond SCREEN_WORDS-1.

Reset
REQ-015 reset=0 SHALL asynchronously force:
- state IDLE, FIFO empty, inflight 0, fetch_addr 0.
- underruns 0, vid_valid 0, mem_write 0.
REQ-016 Reset mid-frame SHALL abandon the frame; after release the block waits for vid_start.

Structure
REQ-017 SHALL place the FSM state enum and SCREEN_WORDS default in a shared package screen_pkg.
REQ-018 SHALL use one sub-module, sync_fifo_16 (parameterised depth, push/pop/count/full/empty), for the prefetch buffer.

Verification
REQ-019 Bench SHALL cover:
- Reset, vid_start, vid_ready=1, no cpu_req, RAM[i]=i -> vid_word 0,1,2,...,8191 in order, underruns=0 after short initial fill, IDLE after word 8191.
- cpu_req=1 with cpu_write=1, address 13'h0005, data 16'hBEEF during RUN -> mem_write=1 that cycle; no fetch issued; word 5 later streams 16'hBEEF if fetched afterwards.
- vid_ready=0 in RUN -> exactly FIFO_DEPTH (4) fetches, then mem_address holds and no fetches until pop.
- cpu_req=1 for 10 cycles with FIFO empty and vid_ready=1 -> underruns=10.
- vid_start at word 100 -> FIFO flushed; next vid_word is RAM[0].
- reset=0 mid-frame -> vid_valid=0 and underruns=0 immediately, without a clock edge.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared types and defaults for the screen memory arbiter and its prefetch FIFO.
package screen_pkg;

  localparam int SCREEN_WORDS_DEFAULT = 8192;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_16.sv
// 16-bit synchronous FIFO with flush; a push is accepted when full only if a pop happens in the same cycle.
module sync_fifo_16
  import screen_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/screen_arbiter.sv
// Screen RAM port arbiter: CPU always wins, idle cycles prefetch the frame into a FIFO for scanout.
// state    | meaning
// ST_IDLE  | waiting for vid_start
// ST_RUN   | fetching words 0..SCREEN_WORDS-1 in free cycles
// ST_DRAIN | last fetch issued, waiting for in-flight word and FIFO to empty
module screen_arbiter
  import screen_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int SCREEN_WORDS = SCREEN_WORDS_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_write,
  input  logic [ADDR_W-1:0]  cpu_address,
  input  logic [DATA_W-1:0]  cpu_data,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [DATA_W-1:0]  mem_data,
  output logic               mem_write,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               vid_start,
  input  logic               vid_ready,
  output logic [DATA_W-1:0]  vid_word,
  output logic               vid_valid,
  output logic [15:0]        underruns
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_WORDS - 1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] fetch_addr;
  logic              inflight;
  logic              fetch;
  logic              flush;
  logic              push;
  logic              pop;
  logic              room;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  // Room means count + inflight < FIFO_DEPTH, so a returning fetch always has a slot.
  assign room = !fifo_full && !(inflight && (fifo_count == CW'(FIFO_DEPTH - 1)));

  always_comb begin
    next_state = state;
    fetch      = 1'b0;
    flush      = 1'b0;
    if (vid_start) begin
      next_state = ST_RUN;
      flush      = 1'b1;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_RUN: begin
          if (!cpu_req && room) begin
            fetch = 1'b1;
            if (fetch_addr == LAST_ADDR) next_state = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!inflight && fifo_empty) next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      fetch_addr <= '0;
      inflight   <= 1'b0;
      underruns  <= 16'd0;
    end else begin
      state    <= next_state;
      inflight <= fetch;
      if (flush) begin
        fetch_addr <= '0;
      end else if (fetch && (fetch_addr != LAST_ADDR)) begin
        fetch_addr <= fetch_addr + ADDR_W'(1);
      end
      if ((state != ST_IDLE) && vid_ready && fifo_empty) begin
        underruns <= sat_inc16(underruns);
      end
    end
  end

  assign push = inflight && !flush;
  assign pop  = vid_ready && !flush;

  sync_fifo_16 #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (mem_rdata),
    .rdata (vid_word),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign vid_valid   = !fifo_empty;
  assign mem_address = cpu_req ? cpu_address : fetch_addr;
  assign mem_data    = cpu_data;
  // Gated by reset so the RAM sees no write while the block is held in reset.
  assign mem_write   = reset && cpu_req && cpu_write;
  assign cpu_rdata   = mem_rdata;

endmodule

// File: tb/tb_screen_arbiter.sv
// Self-checking bench for screen_arbiter: queue-based frame model compared every cycle, plus directed literal checks.
module tb_screen_arbiter;

  localparam int DEPTH = 4;
  localparam int WORDS = 8192;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_write;
  logic [12:0] cpu_address;
  logic [15:0] cpu_data;
  logic [15:0] cpu_rdata;
  logic [12:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_write;
  logic [15:0] mem_rdata;
  logic        vid_start, vid_ready;
  logic [15:0] vid_word;
  logic        vid_valid;
  logic [15:0] underruns;

  screen_arbiter #(.FIFO_DEPTH(DEPTH), .SCREEN_WORDS(WORDS)) dut (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_rdata(cpu_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .vid_start(vid_start), .vid_ready(vid_ready),
    .vid_word(vid_word), .vid_valid(vid_valid), .underruns(underruns)
  );

  always #5 clock = ~clock;

  // Screen RAM: synchronous, read data one cycle after the address.
  logic [15:0] ram [WORDS];
  always @(posedge clock) begin
    if (mem_write) ram[mem_address] <= mem_data;
    mem_rdata <= ram[mem_address];
  end

  // Behavioural model state.
  int          m_mode;            // 0 idle, 1 fetching frame, 2 draining
  int          m_next;
  logic [15:0] m_q[$];
  bit          m_infl;
  logic [15:0] m_infl_data;
  int          m_under;
  bit          m_rd_pend;
  logic [15:0] m_rd_val;
  logic [15:0] shadow [WORDS];

  int n_cmp = 0;
  int n_bad = 0;

  bit          trk_frame = 0;
  int          frame_idx = 0;
  bit          log_en = 0;
  logic [15:0] pop_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0;
    m_next = 0;
    m_q.delete();
    m_infl = 0;
    m_under = 0;
    m_rd_pend = 0;
  endfunction

  always @(negedge clock) begin
    bit fetch, pop, drained;
    if (!reset) model_reset();
    fetch = reset && (m_mode == 1) && !vid_start && !cpu_req &&
            ((m_q.size() + int'(m_infl)) < DEPTH);
    chk("vid_valid", 32'(vid_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("vid_word", 32'(vid_word), 32'(m_q[0]));
    chk("underruns", 32'(underruns), 32'(m_under));
    chk("mem_write", 32'(mem_write), 32'(reset && cpu_req && cpu_write));
    if (cpu_req) begin
      chk("cpu_addr", 32'(mem_address), 32'(cpu_address));
      chk("cpu_wdata", 32'(mem_data), 32'(cpu_data));
    end else if (fetch) begin
      chk("fetch_addr", 32'(mem_address), 32'(m_next));
    end
    if (m_rd_pend) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rd_val));

    if (vid_valid && vid_ready && reset) begin
      if (trk_frame) begin
        chk("frame_word", 32'(vid_word), 32'(frame_idx));
        frame_idx++;
      end
      if (log_en) pop_log.push_back(vid_word);
    end

    if (reset) begin
      pop = vid_ready && (m_q.size() > 0);
      drained = (m_mode == 2) && !m_infl && (m_q.size() == 0);
      if ((m_mode != 0) && vid_ready && (m_q.size() == 0) && (m_under < 65535)) m_under++;
      m_rd_pend = cpu_req && !cpu_write;
      if (m_rd_pend) m_rd_val = shadow[cpu_address];
      if (vid_start) begin
        m_q.delete();
        m_infl = 0;
        m_next = 0;
        m_mode = 1;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_infl_data);
        m_infl = fetch;
        if (fetch) begin
          m_infl_data = shadow[m_next];
          if (m_next == WORDS - 1) m_mode = 2;
          m_next++;
        end
        if (drained) m_mode = 0;
      end
      if (cpu_req && cpu_write) shadow[cpu_address] = cpu_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_log(input int n, input int limit, input string name);
    for (int k = 0; k < limit && pop_log.size() < n; k++) tick();
    chk(name, 32'(pop_log.size() >= n), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram[i] = 16'(i);
      shadow[i] = 16'(i);
    end
    model_reset();
    reset = 1'b0; cpu_req = 0; cpu_write = 0; cpu_address = '0; cpu_data = '0;
    vid_start = 0; vid_ready = 0;
    repeat (3) tick();
    chk("rst_valid", 32'(vid_valid), 32'd0);
    chk("rst_under", 32'(underruns), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Full frame: let the FIFO fill first, then stream every word.
    vid_start = 1; tick(); vid_start = 0;
    repeat (8) tick();
    frame_idx = 0; trk_frame = 1; vid_ready = 1;
    for (int k = 0; k < 9000 && frame_idx < WORDS; k++) tick();
    chk("frame_count", 32'(frame_idx), 32'(WORDS));
    chk("frame_under", 32'(underruns), 32'd0);
    trk_frame = 0;
    repeat (10) tick();
    // exactly one DRAIN cycle sees an empty FIFO with vid_ready high
    chk("frame_end_under", 32'(underruns), 32'd1);
    chk("frame_end_valid", 32'(vid_valid), 32'd0);

    // CPU write during RUN takes the port; word 5 then streams the new data.
    vid_ready = 0;
    vid_start = 1; tick(); vid_start = 0;
    cpu_req = 1; cpu_write = 1; cpu_address = 13'h0005; cpu_data = 16'hBEEF;
    #1;
    chk("cpu_wr_en", 32'(mem_write), 32'd1);
    chk("cpu_wr_addr", 32'(mem_address), 32'h5);
    tick();
    cpu_req = 0; cpu_write = 0;
    pop_log.delete(); log_en = 1; vid_ready = 1;
    wait_log(6, 50, "beef_reach");
    if (pop_log.size() >= 6) begin
      chk("word4", 32'(pop_log[4]), 32'h4);
      chk("beef_word", 32'(pop_log[5]), 32'hBEEF);
    end

    // Stalled scanout: four fetches, then the fetch address holds.
    vid_ready = 0;
    vid_start = 1; tick(); vid_start = 0;
    repeat (10) tick();
    chk("hold_addr", 32'(mem_address), 32'h4);
    tick();
    chk("hold_addr2", 32'(mem_address), 32'h4);
    chk("hold_valid", 32'(vid_valid), 32'd1);

    // Restart mid-frame after 100 words.
    pop_log.delete(); vid_ready = 1;
    wait_log(100, 400, "restart_reach");
    vid_start = 1; tick(); vid_start = 0; vid_ready = 0;
    chk("flush_valid", 32'(vid_valid), 32'd0);
    pop_log.delete(); vid_ready = 1;
    wait_log(1, 20, "restart_first");
    if (pop_log.size() >= 1) chk("restart_word", 32'(pop_log[0]), 32'h0);
    log_en = 0;

    // CPU hogs the port with an empty FIFO: one underrun per cycle.
    reset = 0; tick(); reset = 1; tick();
    vid_ready = 1;
    vid_start = 1; tick(); vid_start = 0;
    cpu_req = 1; cpu_write = 0; cpu_address = 13'h0123;
    repeat (10) tick();
    chk("cpu_starve_under", 32'(underruns), 32'd10);
    cpu_req = 0;

    // Asynchronous reset mid-frame.
    vid_ready = 0;
    repeat (6) tick();
    reset = 0;
    #1;
    chk("async_valid", 32'(vid_valid), 32'd0);
    chk("async_under", 32'(underruns), 32'd0);
    tick();
    reset = 1; vid_ready = 1;
    repeat (5) tick();
    chk("idle_after_reset", 32'(vid_valid), 32'd0);

    // Randomised traffic against the model.
    vid_start = 1; tick(); vid_start = 0;
    for (int k = 0; k < 4000; k++) begin
      cpu_req     = ($urandom_range(0, 9) < 3);
      cpu_write   = $urandom_range(0, 1) == 1;
      cpu_address = 13'($urandom);
      cpu_data    = 16'($urandom);
      vid_ready   = ($urandom_range(0, 3) != 0);
      vid_start   = ($urandom_range(0, 499) == 0);
      tick();
    end
    cpu_req = 0; vid_start = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
